// File: rtl/ddr_pkg.sv
// Shared AXI constants and {addr,data} stream-word layout for the DDR read/write masters.
// Pure declarations: no logic, no latency, no flow control.
package ddr_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Stream word is {addr, data}; data sits in the low bits, address directly above it.
  localparam int STREAM_DATA_LSB = 0;

  function automatic int stream_addr_lsb(input int data_width);
    return STREAM_DATA_LSB + data_width;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ddr_wr_outstanding_ctr.sv
// Up/down outstanding-transaction counter: full/empty flags, simultaneous inc+dec nets to zero.
// Count updates the cycle after inc/dec; dec at zero and inc at full (without dec) are ignored.
module ddr_wr_outstanding_ctr
  import ddr_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty_nxt
);

  localparam int CW = clog2(MAX) + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          inc_eff;
  logic          dec_eff;

  assign full    = (cnt == CW'(MAX));
  assign dec_eff = dec & (cnt != '0);
  // A decrement in the same cycle frees the slot an increment at full would need.
  assign inc_eff = inc & (!full | dec_eff);

  always_comb begin
    cnt_nxt = cnt;
    if (inc_eff && !dec_eff)
      cnt_nxt = cnt + 1'b1;
    else if (dec_eff && !inc_eff)
      cnt_nxt = cnt - 1'b1;
  end

  assign empty_nxt = (cnt_nxt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ddr_axi_wr_master.sv
// Turns each {addr,data} stream word into a single-beat AXI4 write; AW/W valid one cycle after accept.
// Input stalls while a pending AW or W is not being taken or MAX_OUTSTANDING writes await B; DDR_WR_PERF_CNT_EN adds wr_cycles.
module ddr_axi_wr_master
  import ddr_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [7:0]                     m_axi_awlen,
  output logic [2:0]                     m_axi_awsize,
  output logic [1:0]                     m_axi_awburst,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
  output logic                           m_axi_wlast,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  output logic [31:0]                    wr_done_cnt,
  output logic [15:0]                    wr_err_cnt,
`ifdef DDR_WR_PERF_CNT_EN
  output logic [31:0]                    wr_cycles,
`endif
  output logic                           idle
);

  localparam int ADDR_LSB = stream_addr_lsb(DATA_WIDTH);

  logic [1:0] rst_sync;
  logic       rst_i;
  logic       aw_pend;
  logic       w_pend;
  logic       aw_pend_nxt;
  logic       w_pend_nxt;
  logic       accept;
  logic       ost_full;
  logic       ost_empty_nxt;
  logic       b_err;

  // Reset asserts asynchronously but releases two clocks after rstn rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(clog2(DATA_WIDTH / 8));
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = 1'b1;
  assign m_axi_awvalid = aw_pend;
  assign m_axi_wvalid  = w_pend;

  assign s_axis_tready = (!aw_pend | m_axi_awready) & (!w_pend | m_axi_wready) & !ost_full;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign b_err         = (m_axi_bresp == AXI_RESP_SLVERR) | (m_axi_bresp == AXI_RESP_DECERR);

  always_comb begin
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    if (accept)
      aw_pend_nxt = 1'b1;
    else if (m_axi_awready)
      aw_pend_nxt = 1'b0;
    if (accept)
      w_pend_nxt = 1'b1;
    else if (m_axi_wready)
      w_pend_nxt = 1'b0;
  end

  ddr_wr_outstanding_ctr #(
    .MAX (MAX_OUTSTANDING)
  ) u_ost (
    .clk       (clk),
    .rstn      (rst_i),
    .inc       (accept),
    .dec       (m_axi_bvalid),
    .full      (ost_full),
    .empty_nxt (ost_empty_nxt)
  );

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      aw_pend      <= 1'b0;
      w_pend       <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      wr_done_cnt  <= '0;
      wr_err_cnt   <= '0;
      idle         <= 1'b1;
    end else begin
      aw_pend <= aw_pend_nxt;
      w_pend  <= w_pend_nxt;
      // Accept implies both holding slots are free or draining this cycle, so AXI stability holds.
      if (accept) begin
        m_axi_awaddr <= s_axis_tdata[ADDR_LSB +: ADDR_WIDTH];
        m_axi_wdata  <= s_axis_tdata[STREAM_DATA_LSB +: DATA_WIDTH];
      end
      if (m_axi_bvalid) begin
        wr_done_cnt <= wr_done_cnt + 32'd1;
        if (b_err && (wr_err_cnt != 16'hFFFF))
          wr_err_cnt <= wr_err_cnt + 16'd1;
      end
      idle <= !aw_pend_nxt & !w_pend_nxt & ost_empty_nxt;
    end
  end

`ifdef DDR_WR_PERF_CNT_EN
  // The accepting cycle itself counts, so a lone write from idle contributes its full busy span.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i)
      wr_cycles <= '0;
    else if (!idle || accept)
      wr_cycles <= wr_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ddr_axi_wr_master.sv
// Directed bench for ddr_axi_wr_master: single write, streaming, outstanding limit, W stall, errors, reset.
module tb_ddr_axi_wr_master;

  logic        clk;
  logic        rstn;
  logic [95:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] done_cnt;
  logic [15:0] err_cnt;
  logic        idle;
`ifdef DDR_WR_PERF_CNT_EN
  logic [31:0] wr_cycles;
`endif

  int total;
  int bad;
  int acc;
  int drops;
  int aw_n;
  int w_n;
  int addr_bad;
  int data_bad;
  int aw_first;
  int aw_last;

  ddr_axi_wr_master dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .m_axi_awaddr  (awaddr),
    .m_axi_awlen   (awlen),
    .m_axi_awsize  (awsize),
    .m_axi_awburst (awburst),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wlast   (wlast),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .wr_done_cnt   (done_cnt),
    .wr_err_cnt    (err_cnt),
`ifdef DDR_WR_PERF_CNT_EN
    .wr_cycles     (wr_cycles),
`endif
    .idle          (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] mkword(input logic [31:0] a, input logic [63:0] d);
    return {a, d};
  endfunction

  function automatic logic [31:0] s_addr(input int i);
    return 32'h2000_0000 + 32'(i * 8);
  endfunction

  function automatic logic [63:0] s_data(input int i);
    return {32'hA5A5_0000 | 32'(i), 32'(i)};
  endfunction

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0; tvalid = 1'b0; tdata = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    step; step;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_idle", idle, 1);
    chk("const_awsize", awsize, 3);
    chk("const_awburst", awburst, 1);
    chk("const_fixed", {awlen, wstrb, wlast, bready}, {8'h00, 8'hFF, 1'b1, 1'b1});
    rstn = 1'b1;
    step; step; step;

    // single write
    tdata = mkword(32'h1000_0000, 64'hDEAD_BEEF_0123_4567);
    tvalid = 1'b1;
    #1 chk("t1_tready", tready, 1);
    step;
    tvalid = 1'b0;
    chk("t1_awvalid", awvalid, 1);
    chk("t1_wvalid", wvalid, 1);
    chk("t1_awaddr", awaddr, 64'h1000_0000);
    chk("t1_wdata", wdata, 64'hDEAD_BEEF_0123_4567);
    chk("t1_busy", idle, 0);
    step;
    chk("t1_aw_done", awvalid, 0);
    chk("t1_w_done", wvalid, 0);
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_idle", idle, 1);
`ifdef DDR_WR_PERF_CNT_EN
    chk("t1_cycles", wr_cycles, 3);
`endif

    // 256 back-to-back words, B two cycles after W
    drops = 0; aw_n = 0; w_n = 0; addr_bad = 0; data_bad = 0; aw_first = -1; aw_last = -1;
    for (int c = 0; c < 266; c++) begin
      tvalid = (c < 256);
      tdata  = mkword(s_addr(c), s_data(c));
      bvalid = (c >= 3) && (c < 259);
      #1;
      if (tvalid && !tready) drops++;
      if (awvalid) begin
        if (awaddr !== s_addr(aw_n)) addr_bad++;
        if (aw_first < 0) aw_first = c;
        aw_last = c;
        aw_n++;
      end
      if (wvalid) begin
        if (wdata !== s_data(w_n)) data_bad++;
        w_n++;
      end
      step;
    end
    tvalid = 1'b0; bvalid = 1'b0;
    chk("t2_tready_drops", drops, 0);
    chk("t2_aw_count", aw_n, 256);
    chk("t2_w_count", w_n, 256);
    chk("t2_aw_span", aw_last - aw_first, 255);
    chk("t2_addr_order", addr_bad, 0);
    chk("t2_data_order", data_bad, 0);
    chk("t2_done_cnt", done_cnt, 257);
    chk("t2_idle", idle, 1);

    // outstanding limit with no B responses
    tvalid = 1'b1; acc = 0;
    for (int i = 0; i < 12; i++) begin
      tdata = mkword(32'h4000_0000 + 32'(i * 8), 64'(i));
      #1 if (tready) acc++;
      step;
    end
    chk("t3_accepts_full", acc, 8);
    chk("t3_tready_full", tready, 0);
    bvalid = 1'b1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (tready) acc++;
      step;
      bvalid = 1'b0;
    end
    chk("t3_accepts_after_b", acc, 1);
    tvalid = 1'b0; bvalid = 1'b1;
    for (int i = 0; i < 8; i++) step;
    bvalid = 1'b0;
    step;
    chk("t3_done_cnt", done_cnt, 266);
    chk("t3_idle", idle, 1);

    // W channel stalled while AW proceeds
    wready = 1'b0; awready = 1'b1;
    tdata = mkword(32'h3000_0000, 64'h1111_2222_3333_4444);
    tvalid = 1'b1;
    step;
    tdata = mkword(32'h3000_0040, 64'h5555_6666_7777_8888);
    chk("t4_aw_first", awvalid, 1);
    drops = 0; data_bad = 0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (tready) drops++;
      if (!wvalid || wdata !== 64'h1111_2222_3333_4444) data_bad++;
      if (i > 0 && awvalid) acc++;
      step;
    end
    chk("t4_tready_stalled", drops, 0);
    chk("t4_wdata_stable", data_bad, 0);
    chk("t4_aw_alone", acc, 0);
    wready = 1'b1;
    #1 chk("t4_tready_on_w", tready, 1);
    step;
    tvalid = 1'b0;
    chk("t4_awaddr_b", awaddr, 64'h3000_0040);
    chk("t4_wdata_b", wdata, 64'h5555_6666_7777_8888);
    chk("t4_valids_b", {awvalid, wvalid}, 2'b11);
    step;
    bvalid = 1'b1;
    step; step;
    bvalid = 1'b0;
    chk("t4_done_cnt", done_cnt, 268);
    chk("t4_idle", idle, 1);

    // error responses: indices 1,4,7 get SLVERR among 10
    for (int c = 0; c < 16; c++) begin
      tvalid = (c < 10);
      tdata  = mkword(s_addr(c), s_data(c));
      bvalid = (c >= 3) && (c < 13);
      bresp  = ((c - 3 == 1) || (c - 3 == 4) || (c - 3 == 7)) ? 2'b10 : ((c % 2 == 0) ? 2'b01 : 2'b00);
      step;
    end
    tvalid = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    chk("t5_err_cnt", err_cnt, 3);
    chk("t5_done_cnt", done_cnt, 278);
    chk("t5_idle", idle, 1);

    // stray B with nothing outstanding must not underflow
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    chk("t6_stray_counted", done_cnt, 279);
    chk("t6_stray_idle", idle, 1);
    tvalid = 1'b1;
    tdata = mkword(32'h5000_0000, 64'h0F0F);
    step;
    tvalid = 1'b0;
    step;
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    chk("t6_done_cnt", done_cnt, 280);
    chk("t6_no_underflow", idle, 1);

    // reset mid-burst with 4 outstanding and AW pending
    tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdata = mkword(32'h6000_0000 + 32'(i * 8), 64'(i + 1));
      step;
    end
    tvalid = 1'b0; awready = 1'b0;
    step;
    chk("t7_pre_awvalid", awvalid, 1);
    chk("t7_pre_busy", idle, 0);
    rstn = 1'b0;
    #1;
    chk("t7_awvalid", awvalid, 0);
    chk("t7_wvalid", wvalid, 0);
    chk("t7_done", done_cnt, 0);
    chk("t7_err", err_cnt, 0);
    chk("t7_idle", idle, 1);
    chk("t7_awaddr", awaddr, 0);
`ifdef DDR_WR_PERF_CNT_EN
    chk("t7_cycles", wr_cycles, 0);
`endif
    awready = 1'b1;
    step;
    rstn = 1'b1;
    step; step; step;
    tvalid = 1'b1;
    tdata = mkword(32'h7000_0000, 64'hCAFE);
    #1 chk("t7_recover_tready", tready, 1);
    step;
    tvalid = 1'b0;
    chk("t7_recover_awaddr", awaddr, 64'h7000_0000);
    step;
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    chk("t7_recover_done", done_cnt, 1);
    chk("t7_recover_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_axi_wr_master.md
Name: ddr_axi_wr_master

Overview:
- Sits directly downstream of the DDR write-address generator.
- Consumes its AXI-Stream of packed {address, data} words and converts each word into a single-beat AXI4 write to the PS DDR port.
- Tracks outstanding write responses, counts completions and errors, and reports idle so the bandwidth-test controller knows when a layer's output has landed in DDR.

Parameters:
- DATA_WIDTH, 64, AXI write data width in bits; multiple of 8, power of two.
- ADDR_WIDTH, 32, AXI address width.
- MAX_OUTSTANDING, 8, maximum issued-but-unacknowledged writes; power of two, 2..64.

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH+ADDR_WIDTH  [DATA_WIDTH-1:0] is write data; [DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH] is byte address.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  input word accepted when high with tvalid.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awlen  out  8  constant 0 (single beat).
- m_axi_awsize  out  3  constant log2(DATA_WIDTH/8).
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_wstrb  out  DATA_WIDTH/8  all ones.
- m_axi_wlast  out  1  constant 1.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  constant 1.
- wr_done_cnt  out  32  count of B responses received.
- wr_err_cnt  out  16  count of B responses with bresp[1]=1 (SLVERR/DECERR).
- idle  out  1  no pending AW/W and zero outstanding.

Behaviour:
- Reset (async assert, sync deassert inside block): awvalid=0, wvalid=0, awaddr=0, wdata=0, outstanding=0, wr_done_cnt=0, wr_err_cnt=0, idle=1.
- Holding register: aw_pend and w_pend flags drive awvalid and wvalid directly; both are registered outputs.
- Accept condition (combinational): s_axis_tready = (!aw_pend | m_axi_awready) & (!w_pend | m_axi_wready) & (outstanding != MAX_OUTSTANDING).
- On accept (tvalid & tready): next cycle awaddr/wdata load the new word; aw_pend=1, w_pend=1; outstanding increments.
- Latency: accept in cycle N gives awvalid/wvalid high in cycle N+1.
- Throughput: one write per cycle when both readys stay high.
- AW and W channels are independent. Each flag clears on its own handshake unless a new accept reloads it in the same cycle; W may complete before AW and vice versa.
- Once asserted, awvalid/awaddr and wvalid/wdata stay stable until their handshake (AXI rule).
- B channel, per bvalid:
  - outstanding decrements.
  - wr_done_cnt increments, wrapping at 2^32.
  - wr_err_cnt increments if bresp[1]; saturates at 16'hFFFF.
- Accept and B in the same cycle: outstanding is unchanged.
- Outstanding is counted at accept, so a full counter blocks new input even if AW is still pending.
- bvalid with outstanding=0 is a protocol error: ignore the decrement (no underflow) but still count it.
- Address is passed through unmodified; alignment is the upstream's responsibility.
- idle = !aw_pend & !w_pend & (outstanding==0), registered.
- Reset mid-transfer drops pending beats and clears all counters; the interconnect is reset together with this block.

Optional Feature:
- Macro: DDR_WR_PERF_CNT_EN.
- Defined: adds output wr_cycles (32).
  - Cleared at reset.
  - Starts counting on the first accept after idle.
  - Counts every cycle while !idle and freezes when idle returns.
  - Resumes accumulating on the next accept, giving total busy cycles for bandwidth computation.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package ddr_pkg holds:
  - AXI constants AXI_BURST_INCR and AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - A function clog2 for awsize.
  - Field offsets of the packed {addr,data} stream word, shared with the upstream address generator.
- One natural sub-module: ddr_wr_outstanding_ctr, an up/down counter with full, empty and simultaneous inc/dec handling, reused for the future read master.

Test Plan:
- Reset, then one word {addr=32'h1000_0000, data=64'hDEAD_BEEF_0123_4567} with awready=wready=1, bresp=0 one cycle later -> awaddr/wdata match in cycle N+1; wr_done_cnt=1; idle returns to 1.
- 256 back-to-back words with readys tied high, B returned 2 cycles after W -> tready never drops; 256 AW and 256 W handshakes in 256 consecutive cycles.
- bvalid held 0 with MAX_OUTSTANDING=8 -> exactly 8 accepts, then tready=0; one B pulse -> exactly one more accept.
- wready=0 for 5 cycles while awready=1 -> AW completes alone; wdata stays stable; tready=0 until W handshake; order preserved.
- 3 responses with bresp=2'b10 among 10 -> wr_err_cnt=3, wr_done_cnt=10.
- rstn pulsed low mid-burst with 4 outstanding -> all valids drop immediately, counters 0, idle=1; with DDR_WR_PERF_CNT_EN, wr_cycles=0.
